// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM access arbiter.
// Optional round-robin tie-break: SRAM_ARB_ROUND_ROBIN_EN.
package sram_arb_pkg;

    localparam int SRAM_ADDR_BITS = 9;
    localparam int SRAM_DATA_BITS = 16;
    localparam int NUM_PORTS      = 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        COMPLETE
    } sram_arb_state_t;

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Requester-side bus of the SRAM access arbiter.
// master = requester side, slave = arbiter side.
interface sram_access_arbiter_if;
    import sram_arb_pkg::*;

    logic [NUM_PORTS-1:0]                p_req;
    logic [NUM_PORTS-1:0]                p_wen;
    logic [NUM_PORTS*SRAM_ADDR_BITS-1:0] p_addr;
    logic [NUM_PORTS*SRAM_DATA_BITS-1:0] p_wdata;
    logic [NUM_PORTS-1:0]                p_ack;
    logic [SRAM_DATA_BITS-1:0]           p_rdata;
    logic                                grant_id;
    logic                                busy;

    modport master (
        output p_req, p_wen, p_addr, p_wdata,
        input  p_ack, p_rdata, grant_id, busy
    );

    modport slave (
        input  p_req, p_wen, p_addr, p_wdata,
        output p_ack, p_rdata, grant_id, busy
    );

endinterface

// File: rtl/sram_arb_picker.sv
// Winner selection between the two SRAM requesters.
// SRAM_ARB_ROUND_ROBIN_EN adds a last-grant pointer flop.
module sram_arb_picker
    import sram_arb_pkg::*;
(
`ifdef SRAM_ARB_ROUND_ROBIN_EN
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 grant,
`endif
    input  logic [NUM_PORTS-1:0] req,
    output logic                 winner
);

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Remember the last granted port; reset value makes port 0 win the first tie
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            last_q <= 1'b1;
        end else if (grant) begin
            last_q <= winner;
        end
    end

    // Tie goes to the port not granted last; a lone request wins outright
    always_comb begin
        winner = 1'b0;
        unique case (1'b1)
            (req == 2'b11): winner = ~last_q;
            (req == 2'b10): winner = 1'b1;
            default:        winner = 1'b0;
        endcase
    end
`else
    // Port 0 always wins; port 1 only when port 0 is silent
    always_comb begin
        winner = req[1] & ~req[0];
    end
`endif

endmodule

// File: rtl/sram_access_arbiter.sv
// Two-port arbiter/sequencer for the single-port on-chip SRAM.
// Tie-break selected by SRAM_ARB_ROUND_ROBIN_EN (else fixed priority).
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS = SRAM_ADDR_BITS,
    parameter int DATA_BITS = SRAM_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 n_rst,
    sram_access_arbiter_if.slave bus,
    output logic                 sram_read_en,
    output logic                 sram_write_en,
    output logic [ADDR_BITS-1:0] sram_addr,
    output logic [DATA_BITS-1:0] sram_wdata,
    input  logic [DATA_BITS-1:0] sram_rdata
);

    sram_arb_state_t state_q;
    sram_arb_state_t state_d;

    logic                 any_req;
    logic                 win;
    logic [NUM_PORTS-1:0] ack_q;
    logic [DATA_BITS-1:0] rdata_q;
    logic                 grant_q;

    assign any_req = |bus.p_req;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic grant;
    assign grant = (state_q == IDLE) && any_req;
`endif

    sram_arb_picker u_picker (
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        .clk    (clk),
        .n_rst  (n_rst),
        .grant  (grant),
`endif
        .req    (bus.p_req),
        .winner (win)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed three-cycle walk: sample, strobe, acknowledge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (any_req) state_d = ACCESS;
            ACCESS:   state_d = COMPLETE;
            COMPLETE: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // SRAM-facing registers, ack pulse and read-data capture
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            sram_read_en  <= 1'b0;
            sram_write_en <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            ack_q         <= '0;
            rdata_q       <= '0;
            grant_q       <= 1'b0;
        end else begin
            sram_read_en  <= 1'b0;
            sram_write_en <= 1'b0;
            ack_q         <= '0;
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= win;
                        if (win) begin
                            sram_addr     <= bus.p_addr[ADDR_BITS +: ADDR_BITS];
                            sram_wdata    <= bus.p_wdata[DATA_BITS +: DATA_BITS];
                            sram_read_en  <= ~bus.p_wen[1];
                            sram_write_en <= bus.p_wen[1];
                        end else begin
                            sram_addr     <= bus.p_addr[0 +: ADDR_BITS];
                            sram_wdata    <= bus.p_wdata[0 +: DATA_BITS];
                            sram_read_en  <= ~bus.p_wen[0];
                            sram_write_en <= bus.p_wen[0];
                        end
                    end
                end
                ACCESS: begin
                    if (sram_read_en) begin
                        rdata_q <= sram_rdata;
                    end
                    ack_q[grant_q] <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.p_ack    = ack_q;
    assign bus.p_rdata  = rdata_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = (state_q != IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Self-checking bench for sram_access_arbiter with a behavioural SRAM.
// Build with SRAM_ARB_ROUND_ROBIN_EN to check the round-robin variant.
module tb_sram_access_arbiter;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk;
    logic        n_rst;
    logic        sram_read_en;
    logic        sram_write_en;
    logic [8:0]  sram_addr;
    logic [15:0] sram_wdata;
    logic [15:0] sram_rdata;

    sram_access_arbiter_if bus ();

    sram_access_arbiter dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bus           (bus),
        .sram_read_en  (sram_read_en),
        .sram_write_en (sram_write_en),
        .sram_addr     (sram_addr),
        .sram_wdata    (sram_wdata),
        .sram_rdata    (sram_rdata)
    );

    int total = 0;
    int bad = 0;
    bit mon_en = 1'b0;

    logic [15:0] sram_mem [512];
    logic [15:0] ref_mem [512];
    logic        ref_last;

    initial clk = 1'b0;
    always #3 clk = ~clk;

    // Behavioural SRAM wrapper: combinational read, write at the clock edge
    always @(posedge clk) begin
        if (sram_write_en) sram_mem[sram_addr] <= sram_wdata;
    end
    assign sram_rdata = sram_read_en ? sram_mem[sram_addr] : 16'h0000;

    // Cycle invariants: exclusive strobes, one-hot ack, busy tracks occupancy
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((sram_read_en && sram_write_en) || !$onehot0(bus.p_ack) ||
                (bus.busy !== (sram_read_en | sram_write_en | (|bus.p_ack)))) begin
                bad++;
                $display("FAIL invariant re=%b we=%b ack=%b busy=%b",
                         sram_read_en, sram_write_en, bus.p_ack, bus.busy);
            end
        end
    end

    task automatic run_access(
        input  int          port,
        input  logic        wen,
        input  logic [8:0]  addr,
        input  logic [15:0] wd,
        output int          lat,
        output int          strobes,
        output logic [1:0]  ack,
        output logic [15:0] rd,
        output logic [8:0]  saddr,
        output logic        s_we
    );
        @(negedge clk);
        bus.p_wen[port]            = wen;
        bus.p_addr[port*9 +: 9]    = addr;
        bus.p_wdata[port*16 +: 16] = wd;
        bus.p_req[port]            = 1'b1;
        lat = 0; strobes = 0; ack = 2'b00; rd = '0; saddr = '0; s_we = 1'b0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(negedge clk);
            if (sram_read_en || sram_write_en) begin
                strobes++;
                saddr = sram_addr;
                s_we  = sram_write_en;
            end
            if (|bus.p_ack) begin
                lat = c;
                ack = bus.p_ack;
                rd  = bus.p_rdata;
            end
        end
        bus.p_req[port] = 1'b0;
        if (lat != 0) begin
            if (wen) ref_mem[addr] = wd;
            ref_last = port[0];
        end
    endtask

    task automatic test_reset;
        n_rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            bus.p_req   = 2'($urandom_range(0, 3));
            bus.p_wen   = 2'($urandom_range(0, 3));
            bus.p_addr  = 18'($urandom);
            bus.p_wdata = $urandom;
        end
        @(negedge clk);
        mon_en = 1'b1;
        total++;
        if (bus.p_ack !== 2'b00 || bus.busy !== 1'b0 || bus.grant_id !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl ack=%b busy=%b gid=%b want 0", bus.p_ack, bus.busy, bus.grant_id);
        end
        total++;
        if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0) begin
            bad++;
            $display("FAIL reset_en re=%b we=%b want 0", sram_read_en, sram_write_en);
        end
        total++;
        if (sram_addr !== 9'h0 || sram_wdata !== 16'h0 || bus.p_rdata !== 16'h0) begin
            bad++;
            $display("FAIL reset_data addr=%h wd=%h rd=%h want 0", sram_addr, sram_wdata, bus.p_rdata);
        end
        bus.p_req = 2'b00;
        n_rst = 1'b1;
        ref_last = 1'b1;
    endtask

    task automatic test_port0_seq;
        logic        wen_t [3] = '{1'b1, 1'b1, 1'b0};
        logic [15:0] wd_t  [3] = '{16'hFFFF, 16'h0064, 16'h0000};
        int lat, st;
        logic [1:0] ack;
        logic [15:0] rd;
        logic [8:0] sa;
        logic swe;
        for (int i = 0; i < 3; i++) begin
            run_access(0, wen_t[i], 9'h000, wd_t[i], lat, st, ack, rd, sa, swe);
            total++;
            if (lat != 2 || ack !== 2'b01) begin
                bad++;
                $display("FAIL p0seq_ack[%0d] lat=%0d ack=%b want 2/01", i, lat, ack);
            end
            total++;
            if (st != 1 || swe !== wen_t[i] || sa !== 9'h000) begin
                bad++;
                $display("FAIL p0seq_strobe[%0d] n=%0d we=%b a=%h want 1/%b/000", i, st, swe, sa, wen_t[i]);
            end
            if (!wen_t[i]) begin
                total++;
                if (rd !== ref_mem[0]) begin
                    bad++;
                    $display("FAIL p0seq_rdata got=%h want=%h", rd, ref_mem[0]);
                end
            end
        end
    endtask

    task automatic test_tie;
        int c;
        logic exp_p;
        logic got_p;
        @(negedge clk);
        bus.p_wen   = 2'b10;
        bus.p_addr  = {9'h1FF, 9'h010};
        bus.p_wdata = {16'hBEEF, 16'h0000};
        bus.p_req   = 2'b11;
        for (int k = 0; k < 6; k++) begin
            c = 0;
            for (int n = 1; n <= 8 && c == 0; n++) begin
                @(negedge clk);
                if (|bus.p_ack) c = n;
            end
            total++;
            if (c != ((k == 0) ? 2 : 3)) begin
                bad++;
                $display("FAIL tie_spacing[%0d] got=%0d cycles want=%0d", k, c, (k == 0) ? 2 : 3);
                break;
            end
            exp_p = RR ? ~ref_last : 1'b0;
            got_p = bus.p_ack[1];
            total++;
            if (bus.p_ack !== (exp_p ? 2'b10 : 2'b01)) begin
                bad++;
                $display("FAIL tie_grant[%0d] ack=%b want port %0d", k, bus.p_ack, exp_p);
            end
            if (!got_p) begin
                total++;
                if (bus.p_rdata !== ref_mem[9'h010]) begin
                    bad++;
                    $display("FAIL tie_rdata got=%h want=%h", bus.p_rdata, ref_mem[9'h010]);
                end
            end else begin
                ref_mem[9'h1FF] = 16'hBEEF;
            end
            ref_last = got_p;
        end
        bus.p_req = 2'b00;
    endtask

    task automatic test_cross_port;
        int lat, st;
        logic [1:0] ack;
        logic [15:0] rd;
        logic [8:0] sa;
        logic swe;
        run_access(1, 1'b1, 9'h1FF, 16'hA5A5, lat, st, ack, rd, sa, swe);
        total++;
        if (lat != 2 || ack !== 2'b10 || sa !== 9'h1FF || swe !== 1'b1) begin
            bad++;
            $display("FAIL cross_wr lat=%0d ack=%b a=%h we=%b want 2/10/1ff/1", lat, ack, sa, swe);
        end
        run_access(0, 1'b0, 9'h1FF, 16'h0000, lat, st, ack, rd, sa, swe);
        total++;
        if (ack !== 2'b01 || rd !== ref_mem[9'h1FF]) begin
            bad++;
            $display("FAIL cross_rd ack=%b rd=%h want 01/%h", ack, rd, ref_mem[9'h1FF]);
        end
    endtask

    task automatic test_reset_mid;
        int acks;
        int lat, st;
        logic [1:0] ack;
        logic [15:0] rd;
        logic [8:0] sa;
        logic swe;
        @(negedge clk);
        bus.p_wen[0]      = 1'b0;
        bus.p_addr[0 +: 9] = 9'h020;
        bus.p_req         = 2'b01;
        @(negedge clk);
        total++;
        if (sram_read_en !== 1'b1) begin
            bad++;
            $display("FAIL midrst_strobe re=%b want 1", sram_read_en);
        end
        n_rst = 1'b0;
        bus.p_req = 2'b00;
        @(negedge clk);
        total++;
        if (sram_read_en !== 1'b0 || sram_write_en !== 1'b0 || bus.p_ack !== 2'b00 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL midrst_clear re=%b we=%b ack=%b busy=%b want 0",
                     sram_read_en, sram_write_en, bus.p_ack, bus.busy);
        end
        n_rst = 1'b1;
        ref_last = 1'b1;
        acks = 0;
        repeat (3) begin
            @(negedge clk);
            if (|bus.p_ack) acks++;
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL midrst_noack got=%0d acks want 0", acks);
        end
        run_access(1, 1'b1, 9'h020, 16'h1234, lat, st, ack, rd, sa, swe);
        total++;
        if (lat != 2 || ack !== 2'b10) begin
            bad++;
            $display("FAIL midrst_after_wr lat=%0d ack=%b want 2/10", lat, ack);
        end
        run_access(0, 1'b0, 9'h020, 16'h0000, lat, st, ack, rd, sa, swe);
        total++;
        if (ack !== 2'b01 || rd !== 16'h1234) begin
            bad++;
            $display("FAIL midrst_after_rd ack=%b rd=%h want 01/1234", ack, rd);
        end
    endtask

    task automatic test_random;
        logic [1:0]  m;
        logic [1:0]  pend;
        logic [1:0]  wen;
        logic [8:0]  addr [2];
        logic [15:0] wd [2];
        logic        exp_p;
        logic        got_p;
        int          guard;
        for (int r = 0; r < 40; r++) begin
            @(negedge clk);
            m = 2'($urandom_range(1, 3));
            for (int i = 0; i < 2; i++) begin
                wen[i]  = 1'($urandom_range(0, 1));
                addr[i] = {($urandom_range(0, 1) != 0) ? 6'h3F : 6'h00, 3'($urandom_range(0, 7))};
                wd[i]   = 16'($urandom);
                bus.p_wen[i]          = wen[i];
                bus.p_addr[i*9 +: 9]  = addr[i];
                bus.p_wdata[i*16 +: 16] = wd[i];
            end
            bus.p_req = m;
            pend = m;
            guard = 0;
            while (pend != 2'b00 && guard < 12) begin
                @(negedge clk);
                guard++;
                if (|bus.p_ack) begin
                    if (pend == 2'b11) exp_p = RR ? ~ref_last : 1'b0;
                    else               exp_p = pend[1];
                    got_p = bus.p_ack[1];
                    total++;
                    if (bus.p_ack !== (exp_p ? 2'b10 : 2'b01)) begin
                        bad++;
                        $display("FAIL rand_grant[%0d] ack=%b pend=%b want port %0d", r, bus.p_ack, pend, exp_p);
                    end
                    if (!wen[got_p]) begin
                        total++;
                        if (bus.p_rdata !== ref_mem[addr[got_p]]) begin
                            bad++;
                            $display("FAIL rand_rdata[%0d] a=%h got=%h want=%h",
                                     r, addr[got_p], bus.p_rdata, ref_mem[addr[got_p]]);
                        end
                    end else begin
                        ref_mem[addr[got_p]] = wd[got_p];
                    end
                    ref_last = got_p;
                    pend[got_p] = 1'b0;
                    bus.p_req[got_p] = 1'b0;
                end
            end
            if (pend != 2'b00) begin
                total++;
                bad++;
                $display("FAIL rand_timeout[%0d] pending=%b", r, pend);
                bus.p_req = 2'b00;
                repeat (4) @(negedge clk);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 512; i++) begin
            sram_mem[i] = 16'h0000;
            ref_mem[i]  = 16'h0000;
        end
        ref_last    = 1'b1;
        n_rst       = 1'b0;
        bus.p_req   = 2'b00;
        bus.p_wen   = 2'b00;
        bus.p_addr  = '0;
        bus.p_wdata = '0;
        test_reset();
        test_port0_seq();
        test_tie();
        test_cross_port();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
